// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side control FSM for an oversampling UART.
// Sequences start/data/parity/stop bits from an external edge/bit counter,
// pulses the datapath samplers and checkers, and reports frame status.
module uart_rx_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] prescale,
    input  logic [4:0] edge_count,
    input  logic [3:0] bit_count,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       counter_en,
    output logic       cnt_clr,
    output logic       data_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       par_err_o,
    output logic       frm_err_o,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       par_en_q, par_en_d;
    logic [5:0] prescale_q, prescale_d;
    logic       armed_q, armed_d;
    logic       perr_q, perr_d;
    logic       data_valid_q, data_valid_d;
    logic       par_err_o_q, par_err_o_d;
    logic       frm_err_q, frm_err_d;

    logic       ps_legal;
    logic [3:0] bit_lim;
    logic       bit_end;
    logic       chk_edge;
    logic       fault;
    logic       glitch_abort;
    logic       stop_end;

    // Decode bit timing from the frame's latched prescale and flag runaway conditions.
    always_comb begin
        ps_legal = (prescale_q == 6'd8) || (prescale_q == 6'd16) || (prescale_q == 6'd32);
        // Highest bit index allowed before the stop bit; STOP itself is not range-checked.
        bit_lim  = par_en_q ? 4'd9 : 4'd8;
        bit_end  = (state_q != IDLE) && ({1'b0, edge_count} == prescale_q - 6'd1);
        chk_edge = ({1'b0, edge_count} == (prescale_q >> 1) + 6'd2);
        fault    = (state_q != IDLE) &&
                   (!ps_legal || ((state_q != STOP) && (bit_count > bit_lim)));
    end

    // Next-state logic and the combinational counter/datapath enables.
    always_comb begin
        state_d      = state_q;
        glitch_abort = 1'b0;
        stop_end     = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && !rx_in) state_d = START;
            end
            START: begin
                if (bit_end) begin
                    if (strt_glitch) begin
                        state_d      = IDLE;
                        glitch_abort = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_end && (bit_count == 4'd8)) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    stop_end = 1'b1;
                    // A low line at the end of stop is the next frame's start bit.
                    state_d  = rx_in ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fault) begin
            state_d      = IDLE;
            glitch_abort = 1'b0;
            stop_end     = 1'b0;
        end

        counter_en   = (state_q != IDLE);
        data_samp_en = (state_q != IDLE);
        busy         = (state_q != IDLE);
        // Held low during reset so every output reads 0 while rst is asserted.
        cnt_clr      = rst && ((state_q == IDLE) || glitch_abort || stop_end || fault);
        strt_chk_en  = (state_q == START)  && chk_edge;
        deser_en     = (state_q == DATA)   && chk_edge;
        par_chk_en   = (state_q == PARITY) && chk_edge;
        stp_chk_en   = (state_q == STOP)   && chk_edge;
    end

    // Next values for frame configuration, parity capture and status pulses.
    always_comb begin
        armed_d    = armed_q | rx_in;
        par_en_d   = par_en_q;
        prescale_d = prescale_q;
        if ((state_q == IDLE) || (state_d == START)) begin
            par_en_d   = par_en;
            prescale_d = prescale;
        end

        perr_d = perr_q;
        if (!par_en_q || (state_q == IDLE) || (state_q == START)) begin
            perr_d = 1'b0;
        end else if ((state_q == PARITY) && bit_end) begin
            perr_d = par_err;
        end

        data_valid_d = 1'b0;
        par_err_o_d  = 1'b0;
        frm_err_d    = 1'b0;
        if (fault) begin
            frm_err_d = 1'b1;
        end else if (stop_end) begin
            data_valid_d = !perr_q && !stp_err;
            par_err_o_d  = perr_q;
            frm_err_d    = stp_err;
        end
    end

    // Control and status registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            par_en_q     <= 1'b0;
            prescale_q   <= 6'd0;
            armed_q      <= 1'b0;
            perr_q       <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_o_q  <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_en_q     <= par_en_d;
            prescale_q   <= prescale_d;
            armed_q      <= armed_d;
            perr_q       <= perr_d;
            data_valid_q <= data_valid_d;
            par_err_o_q  <= par_err_o_d;
            frm_err_q    <= frm_err_d;
        end
    end

    assign data_valid = data_valid_q;
    assign par_err_o  = par_err_o_q;
    assign frm_err_o  = frm_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl with a behavioural
// edge/bit counter and frame-level timing expectations.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic       par_en;
    logic [5:0] prescale;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       counter_en;
    logic       cnt_clr;
    logic       data_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       par_err_o;
    logic       frm_err_o;
    logic       busy;

    logic       bc_bump;
    logic [10:0] outs;

    int total;
    int bad;
    bit pend_dv, pend_pe, pend_fe;

    uart_rx_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .par_en       (par_en),
        .prescale     (prescale),
        .edge_count   (edge_count),
        .bit_count    (bit_count),
        .strt_glitch  (strt_glitch),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .counter_en   (counter_en),
        .cnt_clr      (cnt_clr),
        .data_samp_en (data_samp_en),
        .deser_en     (deser_en),
        .strt_chk_en  (strt_chk_en),
        .par_chk_en   (par_chk_en),
        .stp_chk_en   (stp_chk_en),
        .data_valid   (data_valid),
        .par_err_o    (par_err_o),
        .frm_err_o    (frm_err_o),
        .busy         (busy)
    );

    assign outs = {counter_en, cnt_clr, data_samp_en, deser_en, strt_chk_en, par_chk_en,
                   stp_chk_en, data_valid, par_err_o, frm_err_o, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External edge/bit counter as it would sit beside the controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_count <= 5'd0;
            bit_count  <= 4'd0;
        end else if (cnt_clr) begin
            edge_count <= 5'd0;
            bit_count  <= 4'd0;
        end else if (counter_en) begin
            if (edge_count == 5'(prescale - 6'd1)) begin
                edge_count <= 5'd0;
                bit_count  <= bit_count + 4'd1 + (bc_bump ? 4'd7 : 4'd0);
            end else begin
                edge_count <= edge_count + 5'd1;
                if (bc_bump) bit_count <= bit_count + 4'd7;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame; expectations derived from frame length L and check-edge position.
    task automatic run_frame(input int P, input bit p, input bit perr, input bit serr,
                             input bit tog, input bit chain_in, input bit chain_out,
                             input int gap, input int exp_len, input bit exp_dv,
                             input bit exp_pe, input bit exp_fe, input string tag);
        int L, last, b, e, m;
        int bad_en, bad_clr, busy_n, quiet;
        logic [3:0] ex_en, ac_en;
        logic [2:0] st;
        logic [7:0] dat;
        L = exp_len;
        dat = 8'($urandom);
        prescale = 6'(P);
        par_en = p;
        strt_glitch = 1'b0;
        bad_en = 0; bad_clr = 0; busy_n = 0; quiet = 0;
        last = chain_out ? L : L + 2;
        if (!chain_in) begin
            rx_in = 1'b1;
            repeat (gap) @(negedge clk);
            rx_in = 1'b0;
        end
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            b = (n - 1) / P;
            e = (n - 1) % P;
            ex_en = 4'b0;
            if (n <= L && e == P / 2 + 2) begin
                ex_en[3] = (b == 0);
                ex_en[2] = (b >= 1 && b <= 8);
                ex_en[1] = p && (b == 9);
                ex_en[0] = (b == 9 + int'(p));
            end
            ac_en = {strt_chk_en, deser_en, par_chk_en, stp_chk_en};
            if (ac_en != ex_en) bad_en++;
            if (counter_en != (n <= L) || data_samp_en != (n <= L)) bad_en++;
            if (busy) busy_n++;
            if (cnt_clr != (n >= L)) bad_clr++;
            st = {data_valid, par_err_o, frm_err_o};
            if (chain_in && n == 1)
                chk({tag, "_prev_status"}, int'(st), int'({pend_dv, pend_pe, pend_fe}));
            else if (!chain_out && n == L + 1)
                chk({tag, "_status"}, int'(st), int'({exp_dv, exp_pe, exp_fe}));
            else if (st != 3'b0)
                quiet++;
            // drive inputs for the next cycle
            if (n == 1) begin
                par_err = perr;
                stp_err = serr;
            end
            if (tog && n == 3 * P) par_en = !p;
            m = n + 1;
            b = n / P;
            if (chain_out && m >= L) rx_in = 1'b0;
            else if (m > L)          rx_in = 1'b1;
            else if (b == 0)         rx_in = 1'b0;
            else if (b <= 8)         rx_in = dat[3'(b - 1)];
            else if (b == 9 && p)    rx_in = ^dat;
            else                     rx_in = 1'b1;
        end
        chk({tag, "_busy_len"}, busy_n, L);
        chk({tag, "_enables"}, bad_en, 0);
        chk({tag, "_cnt_clr"}, bad_clr, 0);
        chk({tag, "_quiet"}, quiet, 0);
        pend_dv = exp_dv;
        pend_pe = exp_pe;
        pend_fe = exp_fe;
    endtask

    typedef struct {
        int P; bit p; bit perr; bit serr; bit tog; bit chain; int gap;
        int len; bit dv; bit pe; bit fe;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int  busy_seen, gq;
        bit  prev_ch, ch, rp, rperr, rserr, rtog, rpe;
        int  rP;

        tbl[0] = '{8,  0, 0, 0, 0, 0, 3,  80, 1, 0, 0};
        tbl[1] = '{16, 1, 1, 0, 0, 0, 2, 176, 0, 1, 0};
        tbl[2] = '{8,  1, 0, 0, 1, 0, 4,  88, 1, 0, 0};
        tbl[3] = '{32, 0, 0, 1, 0, 0, 2, 320, 0, 0, 1};
        tbl[4] = '{8,  0, 1, 0, 0, 0, 2,  80, 1, 0, 0};
        tbl[5] = '{16, 0, 0, 1, 0, 1, 3, 160, 0, 0, 1};
        tbl[6] = '{16, 1, 0, 0, 0, 0, 0, 176, 1, 0, 0};
        tbl[7] = '{8,  0, 0, 0, 1, 0, 2,  80, 1, 0, 0};
        tbl[8] = '{32, 1, 1, 1, 0, 0, 2, 352, 0, 1, 1};

        total = 0; bad = 0;
        pend_dv = 0; pend_pe = 0; pend_fe = 0;
        rst = 1'b0; rx_in = 1'b0; par_en = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0; bc_bump = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", int'(outs), 0);
        rst = 1'b1;

        // line held low after reset must not start a frame
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        chk("arm_ignore_low", busy_seen, 0);
        rx_in = 1'b1;
        @(negedge clk);

        // table-driven frames
        prev_ch = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i].P, tbl[i].p, tbl[i].perr, tbl[i].serr, tbl[i].tog, prev_ch,
                      tbl[i].chain, tbl[i].gap, tbl[i].len, tbl[i].dv, tbl[i].pe, tbl[i].fe,
                      $sformatf("vec%0d", i));
            prev_ch = tbl[i].chain;
        end

        // randomized frames against the frame-level model
        prev_ch = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rP    = 8 << $urandom_range(0, 2);
            rp    = 1'($urandom_range(0, 1));
            rperr = 1'($urandom_range(0, 1));
            rserr = ($urandom_range(0, 3) == 0);
            rtog  = 1'($urandom_range(0, 1));
            ch    = (i < 9) ? ($urandom_range(0, 3) == 0) : 1'b0;
            rpe   = rp & rperr;
            run_frame(rP, rp, rperr, rserr, rtog, prev_ch, ch, int'($urandom_range(2, 6)),
                      (10 + int'(rp)) * rP, !rpe && !rserr, rpe, rserr, $sformatf("rnd%0d", i));
            prev_ch = ch;
        end

        // start-bit glitch aborts with no status
        prescale = 6'd8; par_en = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rx_in = 1'b0;
        strt_glitch = 1'b1;
        gq = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 8) begin
                chk("glitch_busy_at_end", int'(busy), 1);
                chk("glitch_clr_at_end", int'(cnt_clr), 1);
            end
            if (n == 9) begin
                chk("glitch_idle", int'(busy), 0);
                chk("glitch_idle_clr", int'(cnt_clr), 1);
            end
            if ({data_valid, par_err_o, frm_err_o} != 3'b0) gq++;
            if (n == 1) rx_in = 1'b1;
        end
        chk("glitch_quiet", gq, 0);
        strt_glitch = 1'b0;

        // illegal prescale aborts with a framing error
        prescale = 6'd12;
        repeat (2) @(negedge clk);
        rx_in = 1'b0;
        @(negedge clk);
        chk("badps_busy", int'(busy), 1);
        chk("badps_clr", int'(cnt_clr), 1);
        rx_in = 1'b1;
        @(negedge clk);
        chk("badps_idle", int'(busy), 0);
        chk("badps_status", int'({data_valid, par_err_o, frm_err_o}), 1);
        @(negedge clk);
        chk("badps_pulse_end", int'(frm_err_o), 0);
        prescale = 6'd8;

        // runaway bit counter mid-data
        repeat (2) @(negedge clk);
        rx_in = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (n == 21) chk("runaway_clr", int'(cnt_clr), 1);
            if (n == 22) begin
                chk("runaway_idle", int'(busy), 0);
                chk("runaway_status", int'({data_valid, par_err_o, frm_err_o}), 1);
            end
            if (n == 1) rx_in = 1'b1;
            bc_bump = (n == 20);
        end
        bc_bump = 1'b0;

        // reset asserted in the middle of data bit 4
        repeat (2) @(negedge clk);
        rx_in = 1'b0;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (n == 1) rx_in = 1'b1;
        end
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_bitcnt", int'(bit_count), 4);
        rst = 1'b0;
        #1;
        chk("reset_mid_outs", int'(outs), 0);
        @(negedge clk);
        rst = 1'b1;
        run_frame(8, 0, 0, 0, 0, 0, 0, 3, 80, 1, 0, 0, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 clk  in  1  receive clock; all state changes on its rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 rx_in  in  1  serial line; idle high.
REQ-004 par_en  in  1  1 = frame carries a parity bit.
REQ-005 prescale  in  6  oversampling ratio; legal values are 8, 16 and 32.
REQ-006 edge_count  in  5  edge counter value; 0..prescale-1 within each bit.
REQ-007 bit_count  in  4  bit index: 0 = start, 1..8 = data, 9 = parity or stop.
REQ-008 strt_glitch, par_err, stp_err  in  1 each  checker flags, registered by the checkers.
REQ-009 counter_en, cnt_clr  out  1 each  counter enable and synchronous counter clear.
REQ-010 data_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en  out  1 each  datapath enables.
REQ-011 data_valid, par_err_o, frm_err_o, busy  out  1 each  frame status.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-013 "Bit end" SHALL mean counter_en=1 and edge_count==prescale-1.
REQ-014 "Check edge" SHALL mean edge_count==prescale/2+2.
REQ-015 In IDLE, the FSM SHALL move to START when rx_in==0, and stay in IDLE otherwise.
REQ-016 In START at bit end, the FSM SHALL go to IDLE if strt_glitch==1, else to DATA.
REQ-017 In DATA, the FSM SHALL go at bit end with bit_count==8 to PARITY if par_en=1, else to STOP.
REQ-018 PARITY SHALL go to STOP at bit end.
REQ-019 In STOP at bit end, the FSM SHALL go to START if rx_in==0 (back-to-back frame), else to IDLE.
REQ-020 counter_en and data_samp_en SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-021 cnt_clr SHALL be 1 throughout IDLE, in the START-abort cycle and in the STOP bit-end cycle; the counter then reads edge_count=0 and bit_count=0 on START entry.
REQ-022 Enables at the check edge SHALL be single-cycle pulses, decoded combinationally from state and edge_count:
- strt_chk_en in START;
- deser_en in DATA;
- par_chk_en in PARITY;
- stp_chk_en in STOP.
REQ-023 par_err SHALL be captured into an internal register at PARITY bit end.
REQ-024 The internal parity-error register SHALL be forced to 0 when par_en=0.
REQ-025 stp_err SHALL be sampled at STOP bit end.
REQ-026 data_valid, par_err_o and frm_err_o SHALL be registered one-cycle pulses, asserted the cycle after STOP bit end.
REQ-027 data_valid=1 SHALL require no parity error and no stop error.
REQ-028 par_err_o SHALL reflect the captured parity error; frm_err_o SHALL reflect stp_err.
REQ-029 A START abort SHALL produce no status pulse.
REQ-030 busy SHALL be 1 whenever state != IDLE.
REQ-031 par_en and prescale SHALL be sampled only in IDLE and on START entry; changes mid-frame SHALL NOT alter the current frame.
REQ-032 If bit_count>9 (>8 without parity), or prescale is illegal, outside IDLE, the FSM SHALL go to IDLE with cnt_clr=1 and frm_err_o pulsed.

Reset
REQ-033 On rst=0, state SHALL become IDLE and all registered outputs SHALL become 0, regardless of frame progress.
REQ-034 After rst deasserts, the controller SHALL ignore rx_in until it first sees rx_in==1.

Verification
REQ-035 Prescale=8, no parity, 0x55 frame, start low at T0 -> START at T0+1, deser_en at T0+15, T0+23, ... T0+71; data_valid=1 at T0+81 only.
REQ-036 Prescale=16, par_en=1, par_err=1 at PARITY end -> par_err_o=1 and data_valid=0 at T0+177.
REQ-037 Prescale=8, strt_glitch=1 at START end -> IDLE at T0+9, cnt_clr=1, no status pulse, busy=0.
REQ-038 Stop bit sampled low (stp_err=1) -> frm_err_o=1, data_valid=0; rx_in low at STOP end -> START entered directly, two frames received back-to-back.
REQ-039 rst=0 asserted in DATA at bit_count=4 -> all outputs 0 the same cycle; a clean frame after release yields data_valid.
REQ-040 par_en toggled mid-frame -> frame length and status timing unchanged.
